// File: rtl/jtag_command_sequencer.sv
// -----------------------------------------------------------------------------
// jtag_command_sequencer
//
// Takes the instruction/data stream of the JTAG-UART decoder and drives the SLM
// controller's configuration registers, frame-transfer launch and display
// sequence trigger. Multi-byte operands are gathered little-endian into a
// shadow register and committed in a single cycle so downstream blocks never
// see a half-written value.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   -> inter-byte timeout of TIMEOUT_CYCLES clocks while waiting for
//                operand/arm bytes; expiry moves to S_ERROR without a commit.
//   undefined -> no timeout; the block waits for bytes indefinitely.
//
// Ports
//   iCLK, iRST                 clock, synchronous active-high reset
//   iNEW_INSTR, iINSTR         pending instruction flag and 7-bit code
//   iNEW_DATA, iDATA           pending data flag and byte
//   oACK_INSTR, oACK_DATA      combinational consume strobes back to decoder
//   oIDLE_TO_TAKE_COMMAND      high in S_IDLE / S_ERROR
//   oERROR                     high in S_ERROR
//   oOFFSET_H/V, oDISPLAY_CYC,
//   oGALVO_X/Y                 committed configuration registers
//   oCFG_UPDATE                one-hot commit pulse {gy, gx, disp, off_v, off_h}
//   oSEQ_TRIGGER               one-cycle display sequence start
//   oXFER_START/MULTI/FRAME    transfer launch, mode and frame field
//   oXFER_DATA/_VALID          pixel byte stream to the SDRAM writer
//   iXFER_READY, iXFER_DONE    writer back-pressure and completion pulse
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | ready for a command; data bytes left pending with decoder
// S_ERROR    | bad/unknown/out-of-place instruction; waits for INSTRUCTION_ACK
// S_COLLECT  | gathering operand bytes into the shadow register
// S_COMMIT   | one cycle: shadow -> target register, commit pulse
// S_XFER_ARM | waiting for the frame count / frame id byte
// S_XFER     | forwarding pixel bytes until the writer reports done
// -----------------------------------------------------------------------------
module jtag_command_sequencer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iNEW_INSTR,
    input  logic [6:0]  iINSTR,
    input  logic        iNEW_DATA,
    input  logic [7:0]  iDATA,
    output logic        oACK_INSTR,
    output logic        oACK_DATA,
    output logic        oIDLE_TO_TAKE_COMMAND,
    output logic        oERROR,
    output logic [15:0] oOFFSET_H,
    output logic [15:0] oOFFSET_V,
    output logic [23:0] oDISPLAY_CYC,
    output logic [15:0] oGALVO_X,
    output logic [15:0] oGALVO_Y,
    output logic [4:0]  oCFG_UPDATE,
    output logic        oSEQ_TRIGGER,
    output logic        oXFER_START,
    output logic        oXFER_MULTI,
    output logic [5:0]  oXFER_FRAME,
    output logic [7:0]  oXFER_DATA,
    output logic        oXFER_DATA_VALID,
    input  logic        iXFER_READY,
    input  logic        iXFER_DONE
);

    // Instruction codes shared with the JTAG-UART decoder.
    localparam logic [6:0] C_ST_IDLE   = 7'h00;
    localparam logic [6:0] C_ST_ERROR  = 7'h01;
    localparam logic [6:0] C_INSTR_ACK = 7'h02;
    localparam logic [6:0] C_OFF_H     = 7'h10;
    localparam logic [6:0] C_OFF_V     = 7'h11;
    localparam logic [6:0] C_DISP_CYC  = 7'h12;
    localparam logic [6:0] C_GALVO_X   = 7'h13;
    localparam logic [6:0] C_GALVO_Y   = 7'h14;
    localparam logic [6:0] C_SEQ_TRIG  = 7'h20;
    localparam logic [6:0] C_RAM_MULTI = 7'h30;
    localparam logic [6:0] C_RAM_SINGLE= 7'h31;

    // Counter width is derived from TIMEOUT_CYCLES; values below 2 would give
    // a zero-width counter.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERROR,
        S_COLLECT,
        S_COMMIT,
        S_XFER_ARM,
        S_XFER
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    state_t      w_cmd_state;

    logic [23:0] r_shadow;
    logic [1:0]  r_byte_cnt;
    logic [1:0]  r_last_idx;
    logic [2:0]  r_target;
    logic        r_multi;

    logic        w_data_ok;
    logic        w_ack_data;
    logic        w_commit;
    logic        w_run;
    logic        w_cmd_valid;
    logic        w_cmd_go;
    logic [2:0]  w_cmd_target;
    logic [1:0]  w_cmd_last;
    logic        w_cmd_multi;
    logic        w_cmd_seq;
    logic        w_timeout;

    // A pending instruction always blocks data so the instruction wins a tie.
    assign w_data_ok             = iNEW_DATA && !iNEW_INSTR;
    assign oACK_INSTR            = iNEW_INSTR;
    assign oACK_DATA             = w_ack_data;
    assign oIDLE_TO_TAKE_COMMAND = (r_state == S_IDLE) || (r_state == S_ERROR);
    assign oERROR                = (r_state == S_ERROR);

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_waiting;

    assign w_waiting = (r_state == S_COLLECT) || (r_state == S_XFER_ARM);
    assign w_timeout = w_waiting && (r_to_cnt == '0);

    // Down-counter reloaded on entry and on every consumed byte; terminal
    // count reached after TIMEOUT_CYCLES clocks of silence.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_to_cnt <= TO_RELOAD;
        end else if (w_cmd_go || w_ack_data) begin
            r_to_cnt <= TO_RELOAD;
        end else if (w_waiting && (r_to_cnt != '0)) begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_ack_data   = 1'b0;
        w_commit     = 1'b0;
        w_run        = !iNEW_INSTR;
        w_cmd_valid  = 1'b0;
        w_cmd_go     = 1'b0;
        w_cmd_state  = S_IDLE;
        w_cmd_target = 3'd0;
        w_cmd_last   = 2'd0;
        w_cmd_multi  = 1'b0;
        w_cmd_seq    = 1'b0;

        if (iNEW_INSTR) begin
            case (iINSTR)
                C_ST_IDLE:   w_state_nxt = S_IDLE;
                C_ST_ERROR:  w_state_nxt = S_ERROR;
                C_INSTR_ACK: begin
                    // Outside S_ERROR the ack is a no-op and normal work goes on.
                    if (r_state == S_ERROR) w_state_nxt = S_IDLE;
                    else                    w_run       = 1'b1;
                end
                C_OFF_H: begin
                    w_cmd_valid = 1'b1; w_cmd_state = S_COLLECT;
                    w_cmd_target = 3'd0; w_cmd_last = 2'd1;
                end
                C_OFF_V: begin
                    w_cmd_valid = 1'b1; w_cmd_state = S_COLLECT;
                    w_cmd_target = 3'd1; w_cmd_last = 2'd1;
                end
                C_DISP_CYC: begin
                    w_cmd_valid = 1'b1; w_cmd_state = S_COLLECT;
                    w_cmd_target = 3'd2; w_cmd_last = 2'd2;
                end
                C_GALVO_X: begin
                    w_cmd_valid = 1'b1; w_cmd_state = S_COLLECT;
                    w_cmd_target = 3'd3; w_cmd_last = 2'd1;
                end
                C_GALVO_Y: begin
                    w_cmd_valid = 1'b1; w_cmd_state = S_COLLECT;
                    w_cmd_target = 3'd4; w_cmd_last = 2'd1;
                end
                C_SEQ_TRIG: begin
                    w_cmd_valid = 1'b1; w_cmd_state = S_IDLE; w_cmd_seq = 1'b1;
                end
                C_RAM_MULTI: begin
                    w_cmd_valid = 1'b1; w_cmd_state = S_XFER_ARM; w_cmd_multi = 1'b1;
                end
                C_RAM_SINGLE: begin
                    w_cmd_valid = 1'b1; w_cmd_state = S_XFER_ARM;
                end
                default:     w_state_nxt = S_ERROR;
            endcase

            if (w_cmd_valid) begin
                if (r_state == S_IDLE) begin
                    w_cmd_go    = 1'b1;
                    w_state_nxt = w_cmd_state;
                end else begin
                    w_state_nxt = S_ERROR;
                end
            end
        end

        if (w_run) begin
            case (r_state)
                S_COLLECT: begin
                    if (w_data_ok) begin
                        w_ack_data = 1'b1;
                        if (r_byte_cnt == r_last_idx) w_state_nxt = S_COMMIT;
                    end else if (w_timeout) begin
                        w_state_nxt = S_ERROR;
                    end
                end
                S_COMMIT: begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_XFER_ARM: begin
                    if (w_data_ok) begin
                        w_ack_data  = 1'b1;
                        w_state_nxt = S_XFER;
                    end else if (w_timeout) begin
                        w_state_nxt = S_ERROR;
                    end
                end
                S_XFER: begin
                    w_ack_data = w_data_ok && iXFER_READY;
                    if (iXFER_DONE) w_state_nxt = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state          <= S_IDLE;
            r_shadow         <= '0;
            r_byte_cnt       <= '0;
            r_last_idx       <= '0;
            r_target         <= '0;
            r_multi          <= 1'b0;
            oOFFSET_H        <= '0;
            oOFFSET_V        <= '0;
            oDISPLAY_CYC     <= '0;
            oGALVO_X         <= '0;
            oGALVO_Y         <= '0;
            oCFG_UPDATE      <= '0;
            oSEQ_TRIGGER     <= 1'b0;
            oXFER_START      <= 1'b0;
            oXFER_MULTI      <= 1'b0;
            oXFER_FRAME      <= '0;
            oXFER_DATA       <= '0;
            oXFER_DATA_VALID <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            oCFG_UPDATE      <= '0;
            oSEQ_TRIGGER     <= 1'b0;
            oXFER_START      <= 1'b0;
            oXFER_DATA_VALID <= 1'b0;

            if (w_cmd_go) begin
                r_shadow     <= '0;
                r_byte_cnt   <= '0;
                r_last_idx   <= w_cmd_last;
                r_target     <= w_cmd_target;
                r_multi      <= w_cmd_multi;
                oSEQ_TRIGGER <= w_cmd_seq;
            end

            if (w_ack_data && (r_state == S_COLLECT)) begin
                case (r_byte_cnt)
                    2'd0:    r_shadow[7:0]   <= iDATA;
                    2'd1:    r_shadow[15:8]  <= iDATA;
                    default: r_shadow[23:16] <= iDATA;
                endcase
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            if (w_commit) begin
                case (r_target)
                    3'd0:    oOFFSET_H    <= r_shadow[15:0];
                    3'd1:    oOFFSET_V    <= r_shadow[15:0];
                    3'd2:    oDISPLAY_CYC <= r_shadow;
                    3'd3:    oGALVO_X     <= r_shadow[15:0];
                    default: oGALVO_Y     <= r_shadow[15:0];
                endcase
                oCFG_UPDATE <= 5'b00001 << r_target;
            end

            if (w_ack_data && (r_state == S_XFER_ARM)) begin
                oXFER_FRAME <= iDATA[5:0];
                oXFER_MULTI <= r_multi;
                oXFER_START <= 1'b1;
            end

            if (w_ack_data && (r_state == S_XFER)) begin
                oXFER_DATA       <= iDATA;
                oXFER_DATA_VALID <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtag_command_sequencer.sv
module tb_jtag_command_sequencer;

    localparam logic [6:0] C_ST_IDLE    = 7'h00;
    localparam logic [6:0] C_INSTR_ACK  = 7'h02;
    localparam logic [6:0] C_OFF_H      = 7'h10;
    localparam logic [6:0] C_OFF_V      = 7'h11;
    localparam logic [6:0] C_DISP_CYC   = 7'h12;
    localparam logic [6:0] C_GALVO_X    = 7'h13;
    localparam logic [6:0] C_GALVO_Y    = 7'h14;
    localparam logic [6:0] C_SEQ_TRIG   = 7'h20;
    localparam logic [6:0] C_RAM_MULTI  = 7'h30;
    localparam logic [6:0] C_RAM_SINGLE = 7'h31;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iNEW_INSTR = 1'b0;
    logic [6:0]  iINSTR = '0;
    logic        iNEW_DATA = 1'b0;
    logic [7:0]  iDATA = '0;
    logic        iXFER_READY = 1'b0;
    logic        iXFER_DONE = 1'b0;
    logic        oACK_INSTR, oACK_DATA, oIDLE_TO_TAKE_COMMAND, oERROR;
    logic [15:0] oOFFSET_H, oOFFSET_V, oGALVO_X, oGALVO_Y;
    logic [23:0] oDISPLAY_CYC;
    logic [4:0]  oCFG_UPDATE;
    logic        oSEQ_TRIGGER, oXFER_START, oXFER_MULTI, oXFER_DATA_VALID;
    logic [5:0]  oXFER_FRAME;
    logic [7:0]  oXFER_DATA;

    jtag_command_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iNEW_INSTR(iNEW_INSTR), .iINSTR(iINSTR),
        .iNEW_DATA(iNEW_DATA), .iDATA(iDATA),
        .oACK_INSTR(oACK_INSTR), .oACK_DATA(oACK_DATA),
        .oIDLE_TO_TAKE_COMMAND(oIDLE_TO_TAKE_COMMAND), .oERROR(oERROR),
        .oOFFSET_H(oOFFSET_H), .oOFFSET_V(oOFFSET_V),
        .oDISPLAY_CYC(oDISPLAY_CYC),
        .oGALVO_X(oGALVO_X), .oGALVO_Y(oGALVO_Y),
        .oCFG_UPDATE(oCFG_UPDATE), .oSEQ_TRIGGER(oSEQ_TRIGGER),
        .oXFER_START(oXFER_START), .oXFER_MULTI(oXFER_MULTI),
        .oXFER_FRAME(oXFER_FRAME), .oXFER_DATA(oXFER_DATA),
        .oXFER_DATA_VALID(oXFER_DATA_VALID),
        .iXFER_READY(iXFER_READY), .iXFER_DONE(iXFER_DONE)
    );

    always #5 iCLK = ~iCLK;

    int n_chk = 0;
    int n_bad = 0;
    int seq_cnt = 0;
    int cap_n = 0;
    logic [7:0] cap [8];

    always @(negedge iCLK) begin
        if (oSEQ_TRIGGER) seq_cnt++;
        if (oXFER_DATA_VALID) begin
            if (cap_n < 8) cap[cap_n] = oXFER_DATA;
            cap_n++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_instr(input logic [6:0] code);
        iNEW_INSTR = 1'b1;
        iINSTR     = code;
        @(negedge iCLK);
        iNEW_INSTR = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        iNEW_DATA = 1'b1;
        iDATA     = b;
        for (n = 0; n < 50; n++) begin
            #1;
            if (oACK_DATA) break;
            @(negedge iCLK);
        end
        if (n == 50) chk("byte_ack_timeout", 32'd0, 32'd1);
        @(negedge iCLK);
        iNEW_DATA = 1'b0;
    endtask

    function automatic logic [23:0] reg_sel(input logic [4:0] u);
        case (u)
            5'b00001: return {8'h00, oOFFSET_H};
            5'b00010: return {8'h00, oOFFSET_V};
            5'b00100: return oDISPLAY_CYC;
            5'b01000: return {8'h00, oGALVO_X};
            default:  return {8'h00, oGALVO_Y};
        endcase
    endfunction

    typedef struct {
        logic [6:0]  cmd;
        int          nb;
        logic [23:0] bytes;   // byte k at [8k+7:8k], sent k = 0 first
        logic [4:0]  upd;
        logic [23:0] val;
    } cfg_vec_t;

    cfg_vec_t tv [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{C_OFF_H,    2, 24'h001234, 5'b00001, 24'h001234};
        tv[1] = '{C_OFF_V,    2, 24'h00FFFE, 5'b00010, 24'h00FFFE};
        tv[2] = '{C_DISP_CYC, 3, 24'h123456, 5'b00100, 24'h123456};
        tv[3] = '{C_GALVO_X,  2, 24'h00ABCD, 5'b01000, 24'h00ABCD};
        tv[4] = '{C_GALVO_Y,  2, 24'h008001, 5'b10000, 24'h008001};
        tv[5] = '{C_OFF_H,    2, 24'h000000, 5'b00001, 24'h000000};

        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);

        // reset state
        chk("rst_idle", oIDLE_TO_TAKE_COMMAND, 1);
        chk("rst_err", oERROR, 0);
        chk("rst_cfg", {oOFFSET_H, oOFFSET_V}, 0);
        chk("rst_cfg2", {oDISPLAY_CYC, oCFG_UPDATE}, 0);
        chk("rst_galvo", {oGALVO_X, oGALVO_Y}, 0);
        chk("rst_xfer", {oXFER_START, oXFER_MULTI, oXFER_FRAME, oXFER_DATA, oXFER_DATA_VALID, oSEQ_TRIGGER}, 0);

        // aborted display-cycle operand
        send_instr(C_DISP_CYC);
        chk("disp_collect_busy", oIDLE_TO_TAKE_COMMAND, 0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_instr(C_ST_IDLE);
        chk("abort_idle", oIDLE_TO_TAKE_COMMAND, 1);
        chk("abort_upd", oCFG_UPDATE, 0);
        @(negedge iCLK);
        chk("abort_upd2", oCFG_UPDATE, 0);
        chk("abort_disp", oDISPLAY_CYC, 0);

        // table-driven commits
        for (int i = 0; i < 6; i++) begin
            send_instr(tv[i].cmd);
            for (int k = 0; k < tv[i].nb; k++) send_byte(tv[i].bytes[8*k +: 8]);
            chk("commit_early", oCFG_UPDATE, 0);
            @(negedge iCLK);
            chk("commit_pulse", oCFG_UPDATE, tv[i].upd);
            chk("commit_val", reg_sel(tv[i].upd), tv[i].val);
            chk("commit_idle", oIDLE_TO_TAKE_COMMAND, 1);
            @(negedge iCLK);
            chk("commit_end", oCFG_UPDATE, 0);
        end
        chk("keep_off_v", oOFFSET_V, 16'hFFFE);
        chk("keep_disp", oDISPLAY_CYC, 24'h123456);

        // multi-frame transfer, instruction and arm byte presented together
        iXFER_READY = 1'b1;
        cap_n = 0;
        iNEW_INSTR = 1'b1; iINSTR = C_RAM_MULTI;
        iNEW_DATA  = 1'b1; iDATA  = 8'h03;
        #1;
        chk("tie_data_held", oACK_DATA, 0);
        chk("tie_instr_ack", oACK_INSTR, 1);
        @(negedge iCLK);
        iNEW_INSTR = 1'b0;
        #1;
        chk("arm_ack", oACK_DATA, 1);
        @(negedge iCLK);
        iNEW_DATA = 1'b0;
        chk("xfer_start", oXFER_START, 1);
        chk("xfer_multi", oXFER_MULTI, 1);
        chk("xfer_frame", oXFER_FRAME, 6'd3);
        send_byte(8'hAA);
        chk("pix_valid", oXFER_DATA_VALID, 1);
        chk("pix_data", oXFER_DATA, 8'hAA);
        chk("start_once", oXFER_START, 0);
        iXFER_READY = 1'b0;
        iNEW_DATA = 1'b1; iDATA = 8'h55;
        #1;
        chk("notready_ack", oACK_DATA, 0);
        @(negedge iCLK);
        #1;
        chk("notready_ack2", oACK_DATA, 0);
        chk("notready_valid", oXFER_DATA_VALID, 0);
        iXFER_READY = 1'b1;
        send_byte(8'h55);
        send_byte(8'hC3);
        send_byte(8'h3C);
        @(negedge iCLK);
        chk("pix_count", cap_n, 4);
        chk("pix_order", {cap[0], cap[1], cap[2], cap[3]}, 32'hAA55C33C);
        chk("xfer_busy", oIDLE_TO_TAKE_COMMAND, 0);
        iXFER_DONE = 1'b1;
        @(negedge iCLK);
        iXFER_DONE = 1'b0;
        chk("done_idle", oIDLE_TO_TAKE_COMMAND, 1);

        // single-frame transfer; upper arm bits ignored
        send_instr(C_RAM_SINGLE);
        send_byte(8'hC5);
        chk("single_start", oXFER_START, 1);
        chk("single_multi", oXFER_MULTI, 0);
        chk("single_frame", oXFER_FRAME, 6'd5);
        iXFER_DONE = 1'b1;
        @(negedge iCLK);
        iXFER_DONE = 1'b0;
        chk("single_done", oIDLE_TO_TAKE_COMMAND, 1);

        // unknown code, data held in error, then acknowledge
        send_instr(7'h7F);
        chk("unk_err", oERROR, 1);
        chk("unk_idle", oIDLE_TO_TAKE_COMMAND, 1);
        iNEW_DATA = 1'b1; iDATA = 8'h11;
        #1;
        chk("err_data_held", oACK_DATA, 0);
        @(negedge iCLK);
        iNEW_DATA = 1'b0;
        send_instr(C_INSTR_ACK);
        chk("ack_clears", oERROR, 0);
        chk("ack_idle", oIDLE_TO_TAKE_COMMAND, 1);

        // sequence trigger out of place, then in place
        seq_cnt = 0;
        send_instr(C_GALVO_X);
        send_byte(8'h77);
        send_instr(C_SEQ_TRIG);
        chk("seq_bad_err", oERROR, 1);
        repeat (3) @(negedge iCLK);
        chk("seq_bad_none", seq_cnt, 0);
        chk("seq_bad_gx", oGALVO_X, 16'hABCD);
        send_instr(C_INSTR_ACK);
        send_instr(C_SEQ_TRIG);
        chk("seq_pulse", oSEQ_TRIGGER, 1);
        chk("seq_stay_idle", oIDLE_TO_TAKE_COMMAND, 1);
        repeat (3) @(negedge iCLK);
        chk("seq_once", seq_cnt, 1);

        // inter-byte silence
        send_instr(C_GALVO_Y);
        send_byte(8'h99);
`ifdef SEQ_TIMEOUT_EN
        repeat (15) @(negedge iCLK);
        chk("to_not_yet", oIDLE_TO_TAKE_COMMAND, 0);
        @(negedge iCLK);
        chk("to_err", oERROR, 1);
        chk("to_gy_kept", oGALVO_Y, 16'h8001);
        send_instr(C_INSTR_ACK);
`else
        repeat (40) @(negedge iCLK);
        chk("wait_no_err", oERROR, 0);
        chk("wait_busy", oIDLE_TO_TAKE_COMMAND, 0);
        send_instr(C_ST_IDLE);
        chk("wait_gy_kept", oGALVO_Y, 16'h8001);
`endif
        chk("end_idle", oIDLE_TO_TAKE_COMMAND, 1);

        // reset mid-collect drops the partial operand
        send_instr(C_OFF_V);
        send_byte(8'h42);
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        chk("midrst_idle", oIDLE_TO_TAKE_COMMAND, 1);
        chk("midrst_offv", oOFFSET_V, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
